// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU type definitions and small decode helpers.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  // True for the operations that run through the iterative datapath.
  function automatic logic md_is_iter(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the operations that treat their operands as two's complement.
  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for the multiply operations.
  function automatic logic md_is_mul(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// One 2*WIDTH shift register and one WIDTH+1 adder/subtractor are shared by the
// shift-add multiplier and the restoring divider. Operands are iterated as
// magnitudes; signs are applied in a single correction cycle at the end.
module alu_muldiv
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_MUL  | shift-add, one multiplier bit per cycle
  // S_DIV  | restoring divide, one quotient bit per cycle
  // S_FIX  | sign correction and hi/lo write
  // S_DONE | done pulse; accepts a new start like S_IDLE
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_mul_q, is_mul_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               can_accept, accept_iter, last_iter;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     as_a, as_b, as_r;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // A start is only taken when idle or in the done cycle; flush drops it.
  assign can_accept  = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept_iter = can_accept && md_is_iter(op);
  assign last_iter   = (cnt_q == CW'(WIDTH - 1));

  assign neg_a_in = md_is_signed(op) && a[WIDTH-1];
  assign neg_b_in = md_is_signed(op) && b[WIDTH-1];
  assign abs_a    = neg_a_in ? -a : a;
  assign abs_b    = neg_b_in ? -b : b;

  // Shared adder/subtractor: adds the multiplicand in S_MUL, trial-subtracts
  // the divisor from the shifted partial remainder otherwise.
  assign as_a   = (state_q == S_MUL) ? {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                                     : acc_q[2*WIDTH-1:WIDTH-1];
  assign as_b   = {1'b0, opnd_q};
  assign as_r   = (state_q == S_MUL) ? (as_a + (acc_q[0] ? as_b : '0)) : (as_a - as_b);
  assign div_ge = !as_r[WIDTH];

  // Sign correction. A zero divisor keeps the all-ones quotient unsigned so
  // the signed and unsigned divide-by-zero results agree.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_fix  = ((neg_a_q ^ neg_b_q) && (opnd_q != '0)) ? -acc_q[WIDTH-1:0]
                                                            : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (accept_iter) state_d = md_is_mul(op) ? S_MUL : S_DIV;
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath next values: operand capture, one iteration step, final write.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_mul_d = is_mul_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept_iter) begin
      cnt_d    = '0;
      is_mul_d = md_is_mul(op);
      neg_a_d  = neg_a_in;
      neg_b_d  = neg_b_in;
      acc_d    = {{WIDTH{1'b0}}, (md_is_mul(op) ? abs_b : abs_a)};
      opnd_d   = md_is_mul(op) ? abs_a : abs_b;
    end else if (can_accept && (op == MD_MTHI)) begin
      hi_d = a;
    end else if (can_accept && (op == MD_MTLO)) begin
      lo_d = a;
    end else if (!flush) begin
      case (state_q)
        S_MUL: begin
          acc_d = {as_r, acc_q[WIDTH-1:1]};
          cnt_d = last_iter ? '0 : cnt_q + CW'(1);
        end
        S_DIV: begin
          acc_d = {(div_ge ? as_r[WIDTH-1:0] : as_a[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
          cnt_d = last_iter ? '0 : cnt_q + CW'(1);
        end
        S_FIX: begin
          if (is_mul_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_mul_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_mul_q <= is_mul_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed stimulus for alu_muldiv, checked every cycle against
// an arithmetic reference model plus hand-computed literal results.
module tb_alu_muldiv;
  import cpu_types_pkg::*;

  localparam int W = 32;

  logic         CLK   = 1'b0;
  logic         nRST  = 1'b1;
  logic         start = 1'b0;
  muldiv_op_t   op    = MD_MULT;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo} for an iterative op.
  function automatic logic [2*W-1:0] md_model(input muldiv_op_t o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    longint      sx, sy, q, r;
    logic [63:0] res, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      MD_MULT:  res = sx * sy;
      MD_MULTU: res = {32'b0, x} * {32'b0, y};
      MD_DIV, MD_DIVU: begin
        if (y == '0) begin
          res = {x, {W{1'b1}}};
        end else if (o == MD_DIV) begin
          q = sx / sy;
          r = sx % sy;
          qv = q;
          rv = r;
          res = {rv[W-1:0], qv[W-1:0]};
        end else begin
          res = {x % y, x / y};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Cycle-level model: an accepted op keeps the unit busy for W+1 cycles, then
  // hi/lo take the result and done pulses for one cycle.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else if (flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (op == MD_MTHI) m_hi <= a;
        else if (op == MD_MTLO) m_lo <= a;
        else if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
          {p_hi, p_lo} <= md_model(op, a, b);
          m_left       <= W + 1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge CLK) begin
    check("busy", W'(busy), W'(m_left != 0));
    check("done", W'(done), W'(m_done));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  // Present an op for one sampling edge; returns at the next falling edge.
  task automatic issue(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Count falling edges (including the current one) until done, bounded.
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    forever begin
      if (busy) nb++;
      if (done || n >= 60) break;
      @(negedge CLK);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", n);
    end
  endtask

  // Count done pulses and busy cycles over a window.
  task automatic watch(input int cyc_n, output int n_done, output int n_busy);
    n_done = 0;
    n_busy = 0;
    repeat (cyc_n) begin
      @(negedge CLK);
      if (done) n_done++;
      if (busy) n_busy++;
    end
  endtask

  initial begin
    int n, nb, nd;
    #1 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    nRST = 1'b1;
    @(negedge CLK);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(n, nb);
    check("mult_latency", n, 34);
    check("mult_busy_cycles", nb, 33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    @(negedge CLK);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, nb);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(n, nb);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // New start taken in the done cycle.
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFA);
    wait_done(n, nb);
    check("b2b_latency", n, 34);
    check("b2b_hi", hi, 32'hFFFF_FFFF);
    check("b2b_lo", lo, 32'hFFFF_FFD6);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, nb);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, nb);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    issue(MD_DIVU, 32'h0000_1234, 32'd0);
    wait_done(n, nb);
    check("divz_latency", n, 34);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h0000_1234);

    issue(MD_DIV, 32'hFFFF_FFF0, 32'd0);
    wait_done(n, nb);
    check("sdivz_lo", lo, 32'hFFFF_FFFF);
    check("sdivz_hi", hi, 32'hFFFF_FFF0);
    @(negedge CLK);

    // Flush in the 10th busy cycle.
    issue(MD_MULT, 32'd3, 32'd3);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    watch(40, nd, nb);
    check("flush_no_done", nd, 0);
    check("flush_hi", hi, 32'hFFFF_FFF0);
    check("flush_lo", lo, 32'hFFFF_FFFF);

    // Start and flush together: nothing starts.
    start = 1'b1;
    flush = 1'b1;
    op    = MD_DIVU;
    a     = 32'd50;
    b     = 32'd5;
    @(negedge CLK);
    start = 1'b0;
    flush = 1'b0;
    watch(40, nd, nb);
    check("sflush_no_busy", nb, 0);
    check("sflush_no_done", nd, 0);

    // Unused op code is ignored.
    issue(muldiv_op_t'(3'd6), 32'hDEAD_BEEF, 32'd1);
    check("unused_busy", W'(busy), '0);
    check("unused_hi", hi, 32'hFFFF_FFF0);

    // MTHI then MTLO on consecutive edges.
    start = 1'b1;
    op    = MD_MTHI;
    a     = 32'hA5A5_A5A5;
    @(negedge CLK);
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, 32'hFFFF_FFFF);
    check("mthi_busy", W'(busy), '0);
    op = MD_MTLO;
    a  = 32'h5A5A_5A5A;
    @(negedge CLK);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h5A5A_5A5A);
    check("mtlo_hi", hi, 32'hA5A5_A5A5);
    check("mtlo_done", W'(done), '0);

    // Start while busy mid-divide is ignored.
    issue(MD_DIV, 32'd1000, 32'hFFFF_FFFD);
    repeat (4) @(negedge CLK);
    issue(MD_MULTU, 32'd2, 32'd2);
    wait_done(n, nb);
    check("busy_start_latency", n, 29);
    check("busy_start_lo", lo, 32'hFFFF_FEB3);
    check("busy_start_hi", hi, 32'd1);

    // Asynchronous reset in the middle of a multiply.
    issue(MD_MULT, 32'd12345, 32'd678);
    repeat (10) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("arst_busy", W'(busy), '0);
    check("arst_done", W'(done), '0);
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    @(negedge CLK);
    nRST = 1'b1;
    watch(40, nd, nb);
    check("arst_no_done", nd, 0);

    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(n, nb);
    check("post_rst_hi", hi, 32'd1);
    check("post_rst_lo", lo, 32'd0);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
